// File: rtl/flash_vpd_pkg.sv
// Shared definitions for the flash/VPD command-port arbiter.
package flash_vpd_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } flsh_arb_state_t;

   localparam logic [1:0]  RESP_OKAY     = 2'b00;
   localparam logic [1:0]  RESP_SLVERR   = 2'b10;
   localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/flsh_arb_timer.sv
// GRANT-state watchdog: 16-bit counter cleared on grant, counting while enabled.
// Only instantiated when FLASH_CFG_ARB_TIMEOUT_EN is defined.
module flsh_arb_timer #(
   parameter int LIMIT = 65535
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [15:0] cnt_q;

   // Count GRANT cycles; clear takes precedence so every grant starts at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   cnt_q <= '0;
      else if (clr) cnt_q <= '0;
      else if (en)  cnt_q <= cnt_q + 16'd1;
   end

   assign expired = en && (cnt_q == 16'(LIMIT - 1));

endmodule

// File: rtl/flash_cfg_arbiter.sv
// Round-robin arbiter sharing the hold-until-done flash command port between
// the host config path (req0) and the flash-update engine (req1).
// Optional GRANT watchdog: define FLASH_CFG_ARB_TIMEOUT_EN.
module flash_cfg_arbiter
   import flash_vpd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic        clock_afu,
   input  logic        reset_afu_n,
   input  logic [1:0]  req0_devsel,
   input  logic [13:0] req0_addr,
   input  logic        req0_wren,
   input  logic [31:0] req0_wdata,
   input  logic        req0_rden,
   output logic [31:0] req0_rdata,
   output logic        req0_done,
   output logic [1:0]  req0_bresp,
   output logic [1:0]  req0_rresp,
   input  logic [1:0]  req1_devsel,
   input  logic [13:0] req1_addr,
   input  logic        req1_wren,
   input  logic [31:0] req1_wdata,
   input  logic        req1_rden,
   output logic [31:0] req1_rdata,
   output logic        req1_done,
   output logic [1:0]  req1_bresp,
   output logic [1:0]  req1_rresp,
   output logic [1:0]  cfg_flsh_devsel,
   output logic [13:0] cfg_flsh_addr,
   output logic        cfg_flsh_wren,
   output logic [31:0] cfg_flsh_wdata,
   output logic        cfg_flsh_rden,
   input  logic [31:0] flsh_cfg_rdata,
   input  logic        flsh_cfg_done,
   input  logic [1:0]  flsh_cfg_bresp,
   input  logic [1:0]  flsh_cfg_rresp,
   output logic        arb_busy,
   output logic        arb_owner,
   output logic        arb_timeout_err
);

   flsh_arb_state_t  state_q, state_d;
   logic             last_owner_q;
   logic             owner_q;
   logic [1:0]       done_q;
   logic [1:0][31:0] rdata_q;
   logic [1:0][1:0]  bresp_q, rresp_q;
   logic [1:0]       devsel_q;
   logic [13:0]      addr_q;
   logic [31:0]      wdata_q;
   logic             wren_q, rden_q;

   logic [1:0]       act;
   logic             sel, sel_wren, sel_rden, sel_illegal;
   logic [1:0]       sel_devsel;
   logic [13:0]      sel_addr;
   logic [31:0]      sel_wdata;
   logic             grant, fin_ok, fin_to, expired;

   assign act = {req1_wren | req1_rden, req0_wren | req0_rden};

   // On a tie the requester that did not finish last wins.
   assign sel         = act[1] & (~act[0] | ~last_owner_q);
   assign sel_devsel  = sel ? req1_devsel : req0_devsel;
   assign sel_addr    = sel ? req1_addr   : req0_addr;
   assign sel_wdata   = sel ? req1_wdata  : req0_wdata;
   assign sel_wren    = sel ? req1_wren   : req0_wren;
   assign sel_rden    = sel ? req1_rden   : req0_rden;
   assign sel_illegal = sel_wren & sel_rden;

   assign grant  = (state_q == IDLE) && (|act);
   assign fin_ok = (state_q == GRANT) && flsh_cfg_done;
   assign fin_to = (state_q == GRANT) && !flsh_cfg_done && expired;

`ifdef FLASH_CFG_ARB_TIMEOUT_EN
   logic timeout_err_q;

   flsh_arb_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
      .clk     (clock_afu),
      .rst_n   (reset_afu_n),
      .clr     (grant),
      .en      (state_q == GRANT),
      .expired (expired)
   );

   // Sticky abort flag, cleared only by reset.
   always_ff @(posedge clock_afu or negedge reset_afu_n) begin
      if (!reset_afu_n) timeout_err_q <= 1'b0;
      else if (fin_to)  timeout_err_q <= 1'b1;
   end

   assign arb_timeout_err = timeout_err_q;
`else
   logic unused_timeout;
   assign expired         = 1'b0;
   assign arb_timeout_err = 1'b0;
   assign unused_timeout  = ^TIMEOUT_CYCLES;
`endif

   // State register.
   always_ff @(posedge clock_afu or negedge reset_afu_n) begin
      if (!reset_afu_n) state_q <= IDLE;
      else              state_q <= state_d;
   end

   // Next state; an illegal owner skips GRANT and completes with an error.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant) state_d = sel_illegal ? RELEASE : GRANT;
         GRANT:   if (fin_ok || fin_to) state_d = RELEASE;
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Command launch, completion capture and done pulse routing.
   always_ff @(posedge clock_afu or negedge reset_afu_n) begin
      if (!reset_afu_n) begin
         last_owner_q <= 1'b1;
         owner_q      <= 1'b0;
         done_q       <= '0;
         rdata_q      <= '0;
         bresp_q      <= '0;
         rresp_q      <= '0;
         devsel_q     <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wren_q       <= 1'b0;
         rden_q       <= 1'b0;
      end else begin
         done_q <= '0;
         if (grant) begin
            owner_q <= sel;
            if (sel_illegal) begin
               done_q[sel]  <= 1'b1;
               bresp_q[sel] <= RESP_SLVERR;
               rresp_q[sel] <= RESP_SLVERR;
               last_owner_q <= sel;
            end else begin
               devsel_q <= sel_devsel;
               addr_q   <= sel_addr;
               wdata_q  <= sel_wdata;
               wren_q   <= sel_wren;
               rden_q   <= sel_rden;
            end
         end
         if (fin_ok || fin_to) begin
            wren_q           <= 1'b0;
            rden_q           <= 1'b0;
            done_q[owner_q]  <= 1'b1;
            last_owner_q     <= owner_q;
            rdata_q[owner_q] <= fin_ok ? flsh_cfg_rdata : TIMEOUT_RDATA;
            bresp_q[owner_q] <= fin_ok ? flsh_cfg_bresp : RESP_SLVERR;
            rresp_q[owner_q] <= fin_ok ? flsh_cfg_rresp : RESP_SLVERR;
         end
      end
   end

   assign req0_rdata      = rdata_q[0];
   assign req0_done       = done_q[0];
   assign req0_bresp      = bresp_q[0];
   assign req0_rresp      = rresp_q[0];
   assign req1_rdata      = rdata_q[1];
   assign req1_done       = done_q[1];
   assign req1_bresp      = bresp_q[1];
   assign req1_rresp      = rresp_q[1];
   assign cfg_flsh_devsel = devsel_q;
   assign cfg_flsh_addr   = addr_q;
   assign cfg_flsh_wren   = wren_q;
   assign cfg_flsh_wdata  = wdata_q;
   assign cfg_flsh_rden   = rden_q;
   assign arb_busy        = (state_q != IDLE);
   assign arb_owner       = owner_q;

endmodule

// File: tb/tb_flash_cfg_arbiter.sv
// Directed + randomized bench for flash_cfg_arbiter (timeout limit 8 when
// FLASH_CFG_ARB_TIMEOUT_EN is defined).
module tb_flash_cfg_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  r0_devsel = '0, r1_devsel = '0;
   logic [13:0] r0_addr = '0, r1_addr = '0;
   logic        r0_wren = 1'b0, r1_wren = 1'b0, r0_rden = 1'b0, r1_rden = 1'b0;
   logic [31:0] r0_wdata = '0, r1_wdata = '0;
   logic [31:0] r0_rdata, r1_rdata;
   logic        r0_done, r1_done;
   logic [1:0]  r0_bresp, r1_bresp, r0_rresp, r1_rresp;
   logic [1:0]  c_devsel;
   logic [13:0] c_addr;
   logic        c_wren, c_rden;
   logic [31:0] c_wdata;
   logic [31:0] f_rdata = '0;
   logic        f_done = 1'b0;
   logic [1:0]  f_bresp = '0, f_rresp = '0;
   logic        busy, owner, terr;

   int n_checks = 0, n_pass = 0, n_fail = 0;

   // reference-model state
   bit          act[2];
   bit          wr[2];
   logic [1:0]  dv[2];
   logic [13:0] ad[2];
   logic [31:0] wd[2];
   bit          m_last;
   logic [31:0] m_rdata[2];
   logic [1:0]  m_bresp[2], m_rresp[2];

   flash_cfg_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clock_afu(clk), .reset_afu_n(rst_n),
      .req0_devsel(r0_devsel), .req0_addr(r0_addr), .req0_wren(r0_wren),
      .req0_wdata(r0_wdata), .req0_rden(r0_rden), .req0_rdata(r0_rdata),
      .req0_done(r0_done), .req0_bresp(r0_bresp), .req0_rresp(r0_rresp),
      .req1_devsel(r1_devsel), .req1_addr(r1_addr), .req1_wren(r1_wren),
      .req1_wdata(r1_wdata), .req1_rden(r1_rden), .req1_rdata(r1_rdata),
      .req1_done(r1_done), .req1_bresp(r1_bresp), .req1_rresp(r1_rresp),
      .cfg_flsh_devsel(c_devsel), .cfg_flsh_addr(c_addr), .cfg_flsh_wren(c_wren),
      .cfg_flsh_wdata(c_wdata), .cfg_flsh_rden(c_rden),
      .flsh_cfg_rdata(f_rdata), .flsh_cfg_done(f_done),
      .flsh_cfg_bresp(f_bresp), .flsh_cfg_rresp(f_rresp),
      .arb_busy(busy), .arb_owner(owner), .arb_timeout_err(terr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input bit w, input bit r, input logic [1:0] d,
                        input logic [13:0] a, input logic [31:0] wdat);
      if (i == 0) begin
         r0_wren = w; r0_rden = r; r0_devsel = d; r0_addr = a; r0_wdata = wdat;
      end else begin
         r1_wren = w; r1_rden = r; r1_devsel = d; r1_addr = a; r1_wdata = wdat;
      end
   endtask

   function automatic logic get_done(input int i);
      return (i == 0) ? r0_done : r1_done;
   endfunction

   function automatic logic [35:0] get_resp(input int i);
      return (i == 0) ? {r0_rdata, r0_bresp, r0_rresp} : {r1_rdata, r1_bresp, r1_rresp};
   endfunction

   task automatic new_req(input int i);
      act[i] = 1'b1;
      wr[i]  = 1'($urandom_range(0, 1));
      dv[i]  = 2'($urandom);
      ad[i]  = 14'($urandom);
      wd[i]  = $urandom;
      drive(i, wr[i], !wr[i], dv[i], ad[i], wd[i]);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      int w, lat;
      logic [31:0] rd;
      logic [1:0]  br, rr;

      // reset state
      tick();
      chk("rst_outs", {r0_rdata, r0_done, r0_bresp, r0_rresp, r1_rdata, r1_done,
                       r1_bresp, r1_rresp}, '0);
      chk("rst_cmd", {c_devsel, c_addr, c_wren, c_wdata, c_rden}, '0);
      chk("rst_stat", {busy, owner, terr}, '0);
      rst_n = 1'b1;
      tick();

      // spurious downstream done while idle
      f_done = 1'b1; f_rdata = 32'hDEAD_BEEF; f_bresp = 2'b01; f_rresp = 2'b01;
      tick();
      f_done = 1'b0;
      chk("spur_done", {r0_done, r1_done, busy}, '0);
      chk("spur_rdata", {r0_rdata, r1_rdata}, '0);

      // single read from requester 0, downstream done 5 cycles into the grant
      drive(0, 1'b0, 1'b1, 2'd1, 14'h0010, '0);
      tick();
      chk("rd_en", {c_rden, c_wren, c_addr, c_devsel}, {1'b1, 1'b0, 14'h0010, 2'd1});
      chk("rd_busy", {busy, owner}, {1'b1, 1'b0});
      repeat (4) tick();
      f_done = 1'b1; f_rdata = 32'hA5A5_0001; f_bresp = '0; f_rresp = '0;
      tick();
      f_done = 1'b0;
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      chk("rd_done", {r0_done, r1_done, c_rden}, {1'b1, 1'b0, 1'b0});
      chk("rd_rdata", r0_rdata, 32'hA5A5_0001);
      tick();
      chk("rd_idle", {busy, r0_done}, '0);

      // illegal request: both enables set
      drive(0, 1'b1, 1'b1, 2'd2, 14'h0123, 32'h1234_5678);
      tick();
      chk("ill_en", {c_wren, c_rden}, '0);
      chk("ill_done", {r0_done, r1_done, r0_bresp, r0_rresp, busy},
          {1'b1, 1'b0, 2'b10, 2'b10, 1'b1});
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      tick();
      chk("ill_idle", {busy, r0_done}, '0);

      // downstream never answers
      drive(0, 1'b0, 1'b1, 2'd0, 14'h0200, '0);
      tick();
      chk("to_en", c_rden, 1'b1);
`ifdef FLASH_CFG_ARB_TIMEOUT_EN
      repeat (7) tick();
      chk("to_pre", {c_rden, r0_done, terr}, {1'b1, 1'b0, 1'b0});
      tick();
      chk("to_done", {r0_done, c_rden, r0_bresp, r0_rresp, terr},
          {1'b1, 1'b0, 2'b10, 2'b10, 1'b1});
      chk("to_rdata", r0_rdata, 32'hFFFF_FFFF);
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      f_done = 1'b1; f_rdata = 32'h0BAD_0BAD;
      tick();
      f_done = 1'b0;
      chk("to_late", {r0_done, r1_done, busy, terr}, {1'b0, 1'b0, 1'b0, 1'b1});
      chk("to_late_rdata", r0_rdata, 32'hFFFF_FFFF);
`else
      repeat (20) tick();
      chk("nto_hold", {c_rden, r0_done, terr}, {1'b1, 1'b0, 1'b0});
      f_done = 1'b1; f_rdata = 32'h0000_7777;
      tick();
      f_done = 1'b0;
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      chk("nto_done", {r0_done, r0_rdata, terr}, {1'b1, 32'h0000_7777, 1'b0});
      tick();
`endif

      // reset during GRANT clears outputs immediately, no done
      drive(0, 1'b0, 1'b1, 2'd3, 14'h0042, '0);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("arst_cmd", {c_rden, c_wren, c_addr, busy}, '0);
      chk("arst_done", {r0_done, r1_done, terr}, '0);
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("arst_nodone", {r0_done, r1_done, busy}, '0);

      // simultaneous writes: req0 first, req1 three cycles later, then req0 again
      drive(0, 1'b1, 1'b0, 2'd0, 14'h0001, 32'h0000_0011);
      drive(1, 1'b1, 1'b0, 2'd1, 14'h0002, 32'h0000_0022);
      tick();
      chk("tie1_g0", {c_wren, owner, c_wdata}, {1'b1, 1'b0, 32'h0000_0011});
      f_done = 1'b1; f_rdata = '0;
      tick();
      f_done = 1'b0;
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      chk("tie1_d0", {r0_done, r1_done}, {1'b1, 1'b0});
      tick();
      chk("tie1_gap", {c_wren, busy}, '0);
      tick();
      chk("tie1_g1", {c_wren, owner, c_wdata, c_addr}, {1'b1, 1'b1, 32'h0000_0022, 14'h0002});
      f_done = 1'b1;
      tick();
      f_done = 1'b0;
      drive(1, 1'b0, 1'b0, '0, '0, '0);
      chk("tie1_d1", {r0_done, r1_done}, {1'b0, 1'b1});
      tick();
      drive(0, 1'b1, 1'b0, 2'd0, 14'h0003, 32'h0000_0033);
      drive(1, 1'b1, 1'b0, 2'd0, 14'h0004, 32'h0000_0044);
      tick();
      chk("tie2_g0", {c_wren, owner, c_wdata}, {1'b1, 1'b0, 32'h0000_0033});
      f_done = 1'b1;
      tick();
      f_done = 1'b0;
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0, '0);
      tick();
      tick();

      // randomized traffic against the transaction-level model
      do_reset();
      m_last = 1'b1;
      for (int i = 0; i < 2; i++) begin
         act[i] = 1'b0; m_rdata[i] = '0; m_bresp[i] = '0; m_rresp[i] = '0;
      end
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < 2; i++)
            if (!act[i] && $urandom_range(0, 1) == 1) new_req(i);
         if (!act[0] && !act[1]) new_req(int'($urandom_range(0, 1)));
         w = (act[0] && act[1]) ? int'(!m_last) : (act[1] ? 1 : 0);
         tick();
         chk("rnd_grant", {c_wren, c_rden, c_devsel, c_addr, owner, busy},
             {wr[w], !wr[w], dv[w], ad[w], 1'(w), 1'b1});
         if (wr[w]) chk("rnd_wdata", c_wdata, wd[w]);
         lat = $urandom_range(0, 6);
         repeat (lat) tick();
         chk("rnd_hold", {c_wren, c_rden, c_addr, get_done(0), get_done(1)},
             {wr[w], !wr[w], ad[w], 2'b00});
         rd = $urandom; br = 2'($urandom); rr = 2'($urandom);
         f_done = 1'b1; f_rdata = rd; f_bresp = br; f_rresp = rr;
         tick();
         f_done = 1'b0;
         m_rdata[w] = rd; m_bresp[w] = br; m_rresp[w] = rr; m_last = 1'(w);
         chk("rnd_done", {get_done(w), get_done(1 - w), c_wren, c_rden}, {1'b1, 3'b000});
         chk("rnd_resp_own", get_resp(w), {m_rdata[w], m_bresp[w], m_rresp[w]});
         chk("rnd_resp_oth", get_resp(1 - w), {m_rdata[1 - w], m_bresp[1 - w], m_rresp[1 - w]});
         act[w] = 1'b0;
         drive(w, 1'b0, 1'b0, '0, '0, '0);
         tick();
         chk("rnd_rel", {get_done(0), get_done(1), busy}, '0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
